acq_capture_ctrl: RTL and testbench
===================================

# acq_capture_ctrl

Acquisition sequencer for the oscilloscope's data-acquisition path. It accepts the 8-bit ADC sample stream, which the ADC updates on the falling clock edge and this block captures on the rising edge. It writes the samples circularly into a 2^ADDR_W-deep sample RAM, detects a level/slope trigger and stops after a fixed pre/post-trigger window. It reports the oldest-sample address to the host so the host can unroll the capture.

## Interface
- ADDR_W, 10, sample RAM address width; DEPTH = 2^ADDR_W.
- DATA_W, 8, sample width.

- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- sample  in  DATA_W  ADC sample, stable at rising edge.
- sample_en  in  1  sample accepted this cycle when high.
- arm  in  1  start a capture (pulse).
- abort  in  1  cancel any capture and return to IDLE.
- force_trig  in  1  force a trigger on the next eligible sample.
- trig_level  in  DATA_W  trigger threshold, unsigned; latched at arm.
- trig_slope  in  1  0 = rising, 1 = falling; latched at arm.
- pretrig_len  in  ADDR_W  number of samples kept before the trigger sample; latched at arm.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- busy  out  1  high in PRE, WAIT_TRIG and POST.
- triggered  out  1  high from the trigger until the next arm, abort or reset.
- done  out  1  capture complete; high in DONE.
- trig_addr  out  ADDR_W  RAM address of the trigger sample.
- start_addr  out  ADDR_W  RAM address of the oldest captured sample.

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Reset values: state IDLE; all outputs 0; internal counters 0; prev_valid 0.
- An accepted sample is a cycle with sample_en=1 in PRE, WAIT_TRIG or POST.
- On each accepted sample, at the next edge:
  - wr_en=1, wr_data=sample, wr_addr=ptr.
  - ptr increments modulo DEPTH.
  - prev is updated with the sample and prev_valid is set.
- wr_en is 0 on every other cycle.
- IDLE/DONE + arm:
  - Latch trig_level, trig_slope and pretrig_len.
  - Clear ptr, counters, prev_valid, triggered and done.
  - Go to PRE, or to WAIT_TRIG if pretrig_len = 0.
- Arm is ignored while busy.
- PRE:
  - Count accepted samples.
  - After pretrig_len of them, go to WAIT_TRIG.
  - Triggers and force_trig are ignored in PRE.
- WAIT_TRIG: an accepted sample is a trigger when any of these holds:
  - force_trig = 1;
  - rising: prev_valid and prev < level and sample >= level;
  - falling: prev_valid and prev > level and sample <= level.
- WAIT_TRIG writing wraps freely; overwriting old data is intended.
- On trigger:
  - trig_addr = ptr, the address of the trigger sample.
  - triggered = 1.
  - post_cnt is loaded with DEPTH-1-pretrig_len, which equals the bitwise inverse of pretrig_len in ADDR_W bits.
  - Go to POST, or to DONE if post_cnt = 0.
- POST:
  - Each accepted sample decrements post_cnt.
  - The sample that takes post_cnt to 0 is the last one; go to DONE.
- DONE:
  - start_addr = (trig_addr − pretrig_len) mod DEPTH, which equals ptr.
  - The RAM holds exactly DEPTH contiguous samples: pretrig_len samples, then the trigger sample, then the remainder.
  - done stays high until arm, abort or reset.
- abort in any state:
  - Go to IDLE at the next edge.
  - busy, done and triggered are cleared and wr_en is suppressed.
  - abort takes priority over arm, a trigger and sample_en in the same cycle.
- pretrig_len = DEPTH−1: post_cnt = 0, so the capture ends on the trigger sample.

## Timing
- All outputs are registered.
- wr_* appear one cycle after the accepted sample's cycle.
- State changes take effect on the same edge that registers the corresponding write:
  - triggered rises in the same cycle as the trigger sample's wr_en.
  - done rises in the same cycle as the last wr_en.
- start_addr is valid when done rises.
- The host may read the RAM from the cycle after done rises.
- Throughput: one sample per clock with sample_en held high.
- Reset mid-capture: outputs go to their reset values asynchronously. A write that is in flight is dropped.

## Test plan
- Reset: assert reset_n=0 mid-POST -> all outputs 0 immediately; state IDLE after release.
- Ramp capture, ADDR_W=4:
  - Stimulus: ramp source starting at 5, +1 per cycle; sample_en=1; arm so that the first accepted sample = 6; pretrig_len=4; level=20; rising.
  - Required response: trigger on value 20, with trig_addr=14 and triggered rising with that write.
  - Then 11 more writes to addresses 15, 0..9; done rises with the 26th write.
  - start_addr=10; RAM read from address 10 gives 16..31.
- Falling slope, level never crossed, force_trig pulsed in WAIT_TRIG -> trigger on the next accepted sample, trig_addr = that address; force_trig pulsed during PRE has no effect.
- pretrig_len=0, sample equal to level on the first accepted sample -> no trigger, because prev_valid=0. A real crossing later triggers, and start_addr = trig_addr.
- abort in the middle of POST -> IDLE next cycle, no further wr_en, done=0. Then arm and abort asserted together -> stays IDLE.
- sample_en toggling 1010... -> counts, addresses and trigger evaluation advance only on enabled cycles; the total is still DEPTH writes.

Source files
------------

// File: rtl/acq_capture_ctrl.sv
// Acquisition sequencer: circular sample capture into a 2^ADDR_W RAM with
// level/slope trigger and a fixed pre/post-trigger window.
module acq_capture_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_en_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_trig_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic              trig_slope_i,
  input  logic [ADDR_W-1:0] pretrig_len_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [ADDR_W-1:0] start_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic                slope_q, slope_d;
  logic [ADDR_W-1:0]   pretrig_q, pretrig_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                triggered_q, triggered_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;

  logic                in_capture;
  logic                accept;
  logic                rise_hit;
  logic                fall_hit;
  logic                trig_hit;
  logic [ADDR_W-1:0]   ptr_inc;
  logic [ADDR_W-1:0]   pre_cnt_inc;

  // Accepted-sample qualification and trigger detection on the live sample
  assign in_capture  = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign accept      = in_capture && sample_en_i;
  assign rise_hit    = prev_valid_q && (prev_q < level_q) && (sample_i >= level_q);
  assign fall_hit    = prev_valid_q && (prev_q > level_q) && (sample_i <= level_q);
  assign trig_hit    = force_trig_i || (slope_q ? fall_hit : rise_hit);
  assign ptr_inc     = ptr_q + ADDR_W'(1);
  assign pre_cnt_inc = pre_cnt_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      level_q      <= '0;
      slope_q      <= 1'b0;
      pretrig_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      level_q      <= level_d;
      slope_q      <= slope_d;
      pretrig_q    <= pretrig_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    level_d      = level_q;
    slope_d      = slope_q;
    pretrig_d    = pretrig_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    triggered_d  = triggered_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    if (abort_i) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else begin
      // Every accepted sample is written and becomes the slope reference
      if (accept) begin
        wr_en_d      = 1'b1;
        wr_addr_d    = ptr_q;
        wr_data_d    = sample_i;
        ptr_d        = ptr_inc;
        prev_d       = sample_i;
        prev_valid_d = 1'b1;
      end

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            level_d      = trig_level_i;
            slope_d      = trig_slope_i;
            pretrig_d    = pretrig_len_i;
            ptr_d        = '0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            prev_valid_d = 1'b0;
            triggered_d  = 1'b0;
            state_d      = (pretrig_len_i == '0) ? S_WAIT_TRIG : S_PRE;
          end
        end
        S_PRE: begin
          if (accept) begin
            pre_cnt_d = pre_cnt_inc;
            if (pre_cnt_inc == pretrig_q) state_d = S_WAIT_TRIG;
          end
        end
        S_WAIT_TRIG: begin
          if (accept && trig_hit) begin
            trig_addr_d = ptr_q;
            triggered_d = 1'b1;
            post_cnt_d  = ~pretrig_q;
            // A full pre-trigger window leaves no post samples
            if (pretrig_q == '1) begin
              state_d      = S_DONE;
              start_addr_d = ptr_inc;
            end else begin
              state_d = S_POST;
            end
          end
        end
        S_POST: begin
          if (accept) begin
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_q == ADDR_W'(1)) begin
              state_d      = S_DONE;
              start_addr_d = ptr_inc;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_PRE) || (state_d == S_WAIT_TRIG) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign triggered_o  = triggered_q;
  assign done_o       = done_q;
  assign trig_addr_o  = trig_addr_q;
  assign start_addr_o = start_addr_q;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Bench for acq_capture_ctrl: directed and randomized captures checked against
// a sample-list model of the capture window.
module tb_acq_capture_ctrl;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 16;
  localparam int          NSTIM = 48;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] sample_i;
  logic          sample_en_i, arm_i, abort_i, force_trig_i;
  logic [DW-1:0] trig_level_i;
  logic          trig_slope_i;
  logic [AW-1:0] pretrig_len_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o, triggered_o, done_o;
  logic [AW-1:0] trig_addr_o, start_addr_o;

  acq_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_i(sample_i), .sample_en_i(sample_en_i),
    .arm_i(arm_i), .abort_i(abort_i), .force_trig_i(force_trig_i),
    .trig_level_i(trig_level_i), .trig_slope_i(trig_slope_i), .pretrig_len_i(pretrig_len_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
    .triggered_o(triggered_o), .done_o(done_o), .trig_addr_o(trig_addr_o),
    .start_addr_o(start_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          trg;
    logic          dn;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] stim[$];
  bit            frc[$];
  int            n_chk  = 0;
  int            n_fail = 0;

  // Write observer: records every RAM write and mirrors it into a bench RAM
  always @(posedge clk) begin
    #1;
    if (wr_en_o) begin
      wq.push_back('{a: wr_addr_o, d: wr_data_o, trg: triggered_o, dn: done_o});
      mem[wr_addr_o] = wr_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int lo, input int hi);
    stim.delete();
    frc.delete();
    for (int i = 0; i < NSTIM; i++) begin
      stim.push_back(DW'($urandom_range(hi, lo)));
      frc.push_back(1'b0);
    end
  endtask

  // Index of the trigger among accepted samples; -1 if none
  function automatic int find_trig(input int n, input logic [DW-1:0] lvl, input bit slp);
    for (int i = n; i < stim.size(); i++) begin
      if (frc[i]) return i;
      if (i > 0) begin
        if (!slp && stim[i-1] < lvl && stim[i] >= lvl) return i;
        if (slp && stim[i-1] > lvl && stim[i] <= lvl) return i;
      end
    end
    return -1;
  endfunction

  task automatic run_cap(input int n, input logic [DW-1:0] lvl, input bit slp, input bit tog);
    int idx;
    int wsz;
    bit ok;
    wq.delete();
    @(negedge clk);
    arm_i = 1'b1; trig_level_i = lvl; trig_slope_i = slp; pretrig_len_i = AW'(n);
    sample_en_i = 1'b0; force_trig_i = 1'b0;
    @(negedge clk);
    arm_i = 1'b0;
    trig_level_i = DW'($urandom); trig_slope_i = ~slp; pretrig_len_i = AW'($urandom);
    chk("busy_after_arm", 32'(busy_o), 32'(1));
    chk("done_clear_after_arm", 32'(done_o), 32'(0));
    chk("trig_clear_after_arm", 32'(triggered_o), 32'(0));
    idx = 0;
    ok  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      if (done_o) begin ok = 1'b1; break; end
      if (tog && (c % 2 == 1)) begin
        sample_en_i = 1'b0; sample_i = DW'($urandom); force_trig_i = 1'b0;
      end else begin
        sample_en_i  = 1'b1;
        sample_i     = (idx < stim.size()) ? stim[idx] : DW'($urandom);
        force_trig_i = (idx < frc.size()) ? frc[idx] : 1'b0;
        idx++;
      end
    end
    force_trig_i = 1'b0;
    chk("done_within_budget", 32'(ok), 32'(1));
    wsz = wq.size();
    sample_en_i = 1'b1; sample_i = DW'($urandom);
    repeat (3) @(negedge clk);
    sample_en_i = 1'b0;
    chk("no_writes_after_done", 32'(wq.size()), 32'(wsz));
    chk("done_held", 32'(done_o), 32'(1));
  endtask

  task automatic check_cap(input int n, input logic [DW-1:0] lvl, input bit slp);
    int t, last, st;
    t    = find_trig(n, lvl, slp);
    last = (t < 0) ? NSTIM + DEPTH : t + DEPTH - 1 - n;
    st   = (t < 0) ? 0 : (t - n) % DEPTH;
    chk("write_count", 32'(wq.size()), 32'(last + 1));
    for (int i = 0; i < wq.size() && i <= last; i++) begin
      chk("wr_addr", 32'(wq[i].a), 32'(i % DEPTH));
      chk("wr_data", 32'(wq[i].d), 32'(stim[i]));
      chk("triggered_with_write", 32'(wq[i].trg), 32'(i >= t));
      chk("done_with_write", 32'(wq[i].dn), 32'(i == last));
    end
    chk("trig_addr", 32'(trig_addr_o), 32'((t < 0 ? 0 : t) % DEPTH));
    chk("start_addr", 32'(start_addr_o), 32'(st));
    chk("triggered_held", 32'(triggered_o), 32'(1));
    chk("busy_low_done", 32'(busy_o), 32'(0));
    if (last < stim.size()) begin
      for (int j = 0; j < DEPTH; j++)
        chk("ram_unrolled", 32'(mem[(st + j) % DEPTH]), 32'(stim[last - DEPTH + 1 + j]));
    end
  endtask

  // Arm and feed samples until the trigger has been observed
  task automatic arm_until_trig(output bit seen);
    @(negedge clk);
    arm_i = 1'b1; trig_level_i = 8'd128; trig_slope_i = 1'b0; pretrig_len_i = AW'(2);
    sample_en_i = 1'b0;
    @(negedge clk);
    arm_i = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (triggered_o) begin seen = 1'b1; break; end
      sample_en_i = 1'b1;
      sample_i    = (c < 4) ? 8'd10 : 8'd200;
      @(negedge clk);
    end
    chk("trigger_seen", 32'(seen), 32'(1));
  endtask

  initial begin
    int  n, lvl, wsz;
    bit  slp, seen;

    reset_n = 1'b0; sample_i = '0; sample_en_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0;
    force_trig_i = 1'b0; trig_level_i = '0; trig_slope_i = 1'b0; pretrig_len_i = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #12;
    chk("rst_wr_en", 32'(wr_en_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    chk("rst_triggered", 32'(triggered_o), 32'(0));
    chk("rst_trig_addr", 32'(trig_addr_o), 32'(0));
    chk("rst_start_addr", 32'(start_addr_o), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Ramp capture, rising through 20 with four pre-trigger samples
    stim.delete(); frc.delete();
    for (int i = 0; i < NSTIM; i++) begin stim.push_back(DW'(6 + i)); frc.push_back(1'b0); end
    run_cap(4, 8'd20, 1'b0, 1'b0);
    check_cap(4, 8'd20, 1'b0);
    chk("ramp_trig_addr", 32'(trig_addr_o), 32'(14));
    chk("ramp_start_addr", 32'(start_addr_o), 32'(10));
    chk("ramp_writes", 32'(wq.size()), 32'(26));
    chk("ramp_ram_oldest", 32'(mem[10]), 32'(16));

    // Falling slope never crossed: only the WAIT_TRIG force counts
    fill_rand(100, 255);
    frc[3] = 1'b1;
    frc[8] = 1'b1;
    run_cap(5, 8'd50, 1'b1, 1'b0);
    check_cap(5, 8'd50, 1'b1);
    chk("force_trig_addr", 32'(trig_addr_o), 32'(8));

    // No pre-trigger: a sample equal to level first is not a crossing
    fill_rand(0, 255);
    stim[0] = 8'd100; stim[1] = 8'd50; stim[2] = 8'd120;
    run_cap(0, 8'd100, 1'b0, 1'b0);
    check_cap(0, 8'd100, 1'b0);
    chk("pt0_start_eq_trig", 32'(start_addr_o), 32'(trig_addr_o));
    chk("pt0_trig_addr", 32'(trig_addr_o), 32'(2));

    // Full pre-trigger window ends on the trigger sample itself
    fill_rand(0, 255);
    frc[NSTIM - DEPTH] = 1'b1;
    run_cap(DEPTH - 1, 8'd128, 1'b0, 1'b0);
    check_cap(DEPTH - 1, 8'd128, 1'b0);

    // Randomized captures, alternating gapped and continuous sample_en
    for (int k = 0; k < 4; k++) begin
      fill_rand(0, 255);
      frc[NSTIM - DEPTH] = 1'b1;
      n   = int'($urandom_range(14, 1));
      lvl = int'($urandom_range(220, 30));
      slp = 1'($urandom);
      run_cap(n, DW'(lvl), slp, (k % 2) == 0);
      check_cap(n, DW'(lvl), slp);
    end

    // Abort mid-POST, then arm and abort together
    arm_until_trig(seen);
    repeat (2) @(negedge clk);
    abort_i = 1'b1; sample_en_i = 1'b1; sample_i = 8'd77;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'(0));
    chk("abort_done", 32'(done_o), 32'(0));
    chk("abort_triggered", 32'(triggered_o), 32'(0));
    chk("abort_wr_suppressed", 32'(wr_en_o), 32'(0));
    wsz = wq.size();
    repeat (4) @(negedge clk);
    chk("abort_no_writes", 32'(wq.size()), 32'(wsz));
    arm_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0; abort_i = 1'b0;
    chk("arm_abort_idle", 32'(busy_o), 32'(0));
    @(negedge clk);
    chk("arm_abort_no_write", 32'(wr_en_o), 32'(0));
    sample_en_i = 1'b0;

    // Asynchronous reset mid-POST
    arm_until_trig(seen);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid_rst_wr_en", 32'(wr_en_o), 32'(0));
    chk("amid_rst_wr_addr", 32'(wr_addr_o), 32'(0));
    chk("amid_rst_wr_data", 32'(wr_data_o), 32'(0));
    chk("amid_rst_busy", 32'(busy_o), 32'(0));
    chk("amid_rst_triggered", 32'(triggered_o), 32'(0));
    chk("amid_rst_trig_addr", 32'(trig_addr_o), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    sample_en_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy_o), 32'(0));
    chk("post_rst_no_write", 32'(wr_en_o), 32'(0));
    sample_en_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
